// File: rtl/axi_memory_reader_pkg.sv
// axi_memory_reader_pkg: shared AXI constants and engine state type
package axi_memory_reader_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
endpackage

// File: rtl/memory_read_interface.sv
// memory_read_interface: byte-addressed read command handshake between requester and reader
interface memory_read_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0] len;
  logic start;
  logic cont;
  logic busy;
  logic done;
  logic error;
  modport master (output addr, len, start, cont, input busy, done, error);
  modport slave (input addr, len, start, cont, output busy, done, error);
endinterface

// File: rtl/memory_read_burst_calc.sv
// memory_read_burst_calc: beats for the next burst, min of remaining, max burst and 4 KiB headroom
module memory_read_burst_calc #(
  parameter int LEN_WIDTH = 32,
  parameter int SIZE = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0]          offset,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats
);
  logic [12:0] to_4k;
  logic [LEN_WIDTH-1:0] cap;
  logic [LEN_WIDTH-1:0] lim;
  always_comb begin
    to_4k = (13'h1000 - {1'b0, offset}) >> SIZE;
    cap = remaining < LEN_WIDTH'(MAX_BURST_LEN) ? remaining : LEN_WIDTH'(MAX_BURST_LEN);
    lim = LEN_WIDTH'(to_4k) < cap ? LEN_WIDTH'(to_4k) : cap;
    beats = lim[8:0];
  end
endmodule

// File: rtl/axi_memory_reader.sv
// axi_memory_reader: splits read commands into AXI4 INCR bursts and streams returned data
module axi_memory_reader
  import axi_memory_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_read_interface.slave   mri,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_q, cmd_addr, calc_addr, step;
  logic [LEN_WIDTH-1:0] rem, cmd_beats, calc_rem;
  logic [CW-1:0] outstanding, out_next;
  logic [8:0] beats;
  logic idle, accept, misaligned, ar_hs, r_hs, r_end, can_load, room;
  logic busy, done, error;
  memory_read_burst_calc #(
    .LEN_WIDTH(LEN_WIDTH), .SIZE(SIZE), .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_calc (
    .offset(calc_addr[11:0]), .remaining(calc_rem), .beats(beats)
  );
  // rem and addr_q advance when an AR is loaded, so they describe what is still to be issued
  always_comb begin
    idle = state == IDLE || state == FINISH;
    accept = idle && (mri.start || mri.cont);
    cmd_addr = mri.start ? mri.addr : addr_q;
    cmd_beats = mri.len >> SIZE;
    misaligned = |(cmd_addr & ADDR_WIDTH'(BPB - 1)) || |(mri.len & LEN_WIDTH'(BPB - 1));
    calc_addr = idle ? cmd_addr : addr_q;
    calc_rem = idle ? cmd_beats : rem;
    step = ADDR_WIDTH'(beats) << SIZE;
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs = m_axi_rvalid && m_ready;
    r_end = r_hs && m_axi_rlast;
    out_next = outstanding + CW'(ar_hs) - CW'(r_end);
    room = out_next < CW'(MAX_OUTSTANDING);
    can_load = !m_axi_arvalid || m_axi_arready;
  end
  assign mri.busy = busy;
  assign mri.done = done;
  assign mri.error = error;
  assign m_axi_arsize = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_rready = m_ready;
  assign m_data = m_axi_rdata;
  assign m_valid = m_axi_rvalid;
  assign m_last = m_axi_rlast && outstanding == CW'(1) && rem == '0 && !m_axi_arvalid && !idle;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      rem <= '0;
      outstanding <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
    end else begin
      outstanding <= out_next;
      done <= 1'b0;
      if (r_hs && m_axi_rresp != AXI_RESP_OKAY) error <= 1'b1;
      case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          busy <= 1'b0;
          if (accept) begin
            addr_q <= cmd_addr;
            error <= 1'b0;
            if (mri.len == '0) begin
              state <= FINISH;
              done <= 1'b1;
            end else if (misaligned) begin
              state <= FINISH;
              done <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= ISSUE;
              busy <= 1'b1;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr <= cmd_addr;
              m_axi_arlen <= 8'(beats - 9'd1);
              addr_q <= cmd_addr + step;
              rem <= cmd_beats - LEN_WIDTH'(beats);
            end
          end
        end
        ISSUE: if (can_load) begin
          m_axi_arvalid <= rem != '0 && room;
          if (rem != '0 && room) begin
            m_axi_araddr <= addr_q;
            m_axi_arlen <= 8'(beats - 9'd1);
            addr_q <= addr_q + step;
            rem <= rem - LEN_WIDTH'(beats);
          end
          if (rem == '0) state <= DRAIN;
        end
        DRAIN: if (out_next == '0) begin
          state <= FINISH;
          busy <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_memory_reader.sv
// tb_axi_memory_reader: table-driven check of burst splitting, streaming, done timing and errors
module tb_axi_memory_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp;
  logic arvalid, arready, rlast, rvalid, rready, m_valid, m_last, m_ready;
  logic [127:0] rdata, m_data;
  memory_read_interface #(.ADDR_WIDTH(32), .LEN_WIDTH(32)) mri ();
  axi_memory_reader dut (
    .clock(clk), .reset(reset), .mri(mri),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit s; logic [31:0] addr; logic [31:0] len; int ars;
    logic [31:0] a0; logic [7:0] l0; logic [31:0] a1; logic [7:0] l1;
    int beats; bit err; int err_beat; bit bp; bit imm;
  } vec_t;
  typedef struct { logic [31:0] a; int n; } burst_t;
  vec_t vecs[10];
  burst_t q[$];
  int n_checks = 0, n_fail = 0;
  int samp = 0, bi = 0, r_idx = 0, err_beat = -1;
  int ar_cnt = 0, beat_cnt = 0, data_bad = 0, last_bad = 0, ar_bad = 0, exp_beats = 0;
  int last_r_samp = 0, done_samp = 0, n;
  bit ar_en = 1, r_en = 1, bp = 0, p_ar = 0, p_r = 0, to, busy_t1, arv_t1, done_t1;
  logic [31:0] ar_a[16], p_addr, exp_base = 0, next_addr = 0;
  logic [7:0] ar_l[16], p_len;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // AXI slave memory: data of each beat is its own byte address
  always @(negedge clk) begin
    samp++;
    if (reset) begin
      q.delete();
      bi = 0;
      p_ar = 0;
      p_r = 0;
    end
    if (p_ar) q.push_back('{p_addr, int'(p_len) + 1});
    if (p_r) begin
      bi++;
      r_idx++;
      if (bi == q[0].n) begin
        void'(q.pop_front());
        bi = 0;
      end
    end
    arready = ar_en;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    rvalid = r_en && q.size() > 0;
    rdata = rvalid ? 128'(q[0].a + 32'(bi * 16)) : '0;
    rlast = rvalid && bi == q[0].n - 1;
    rresp = (rvalid && r_idx == err_beat) ? 2'b10 : 2'b00;
    #1;
    p_ar = arvalid && arready && !reset;
    p_r = m_valid && m_ready && !reset;
    if (p_ar) begin
      p_addr = araddr;
      p_len = arlen;
      if (ar_cnt < 16) begin
        ar_a[ar_cnt] = araddr;
        ar_l[ar_cnt] = arlen;
      end
      if (arsize !== 3'd4 || arburst !== 2'b01) ar_bad++;
      ar_cnt++;
    end
    if (p_r) begin
      if (m_data !== 128'(exp_base + 32'(beat_cnt * 16))) data_bad++;
      if (m_last !== (beat_cnt == exp_beats - 1)) last_bad++;
      beat_cnt++;
      last_r_samp = samp;
    end
  end
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] l, input int eb);
    @(negedge clk);
    mri.start = s;
    mri.cont = !s;
    mri.addr = a;
    mri.len = l;
    ar_cnt = 0;
    beat_cnt = 0;
    data_bad = 0;
    last_bad = 0;
    ar_bad = 0;
    r_idx = 0;
    exp_beats = eb;
    exp_base = s ? a : next_addr;
    if (s) next_addr = a;
    if (l != 0 && l[3:0] == 0 && exp_base[3:0] == 0) next_addr = exp_base + l;
    @(negedge clk);
    mri.start = 1'b0;
    mri.cont = 1'b0;
    #2;
    busy_t1 = mri.busy;
    arv_t1 = arvalid;
    done_t1 = mri.done;
  endtask
  task automatic wait_done();
    n = 0;
    while (!mri.done && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    to = !mri.done;
    done_samp = samp;
  endtask
  initial begin
    vecs[0] = '{1, 32'h1000, 32'h100, 1, 32'h1000, 15, 0, 0, 16, 0, -1, 0, 0};
    vecs[1] = '{0, 32'h0, 32'h40, 1, 32'h1100, 3, 0, 0, 4, 0, -1, 0, 0};
    vecs[2] = '{1, 32'h0FC0, 32'h80, 2, 32'h0FC0, 3, 32'h1000, 3, 8, 0, -1, 0, 0};
    vecs[3] = '{1, 32'h0FC0, 32'h80, 2, 32'h0FC0, 3, 32'h1000, 3, 8, 0, -1, 1, 0};
    vecs[4] = '{1, 32'h3000, 32'h100, 1, 32'h3000, 15, 0, 0, 16, 1, 1, 0, 0};
    vecs[5] = '{1, 32'h4000, 32'h40, 1, 32'h4000, 3, 0, 0, 4, 0, -1, 0, 0};
    vecs[6] = '{1, 32'h5000, 32'h0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 1};
    vecs[7] = '{1, 32'h1004, 32'h10, 0, 0, 0, 0, 0, 0, 1, -1, 0, 1};
    vecs[8] = '{1, 32'h7F80, 32'h200, 3, 32'h7F80, 7, 32'h8000, 15, 32, 0, -1, 1, 0};
    vecs[9] = '{1, 32'h9000, 32'h18, 0, 0, 0, 0, 0, 0, 1, -1, 0, 1};
    mri.start = 1'b0;
    mri.cont = 1'b0;
    mri.addr = '0;
    mri.len = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", mri.busy, 0);
    check("rst_done", mri.done, 0);
    check("rst_error", mri.error, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_m_last", m_last, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ar_en = 1;
      r_en = 1;
      bp = vecs[i].bp;
      err_beat = vecs[i].err_beat;
      issue(vecs[i].s, vecs[i].addr, vecs[i].len, vecs[i].beats);
      wait_done();
      $display("vector %0d", i);
      check("timeout", to, 0);
      check("ar_count", ar_cnt, vecs[i].ars);
      if (vecs[i].ars > 0) begin
        check("ar0_addr", ar_a[0], vecs[i].a0);
        check("ar0_len", ar_l[0], vecs[i].l0);
      end
      if (vecs[i].ars > 1) begin
        check("ar1_addr", ar_a[1], vecs[i].a1);
        check("ar1_len", ar_l[1], vecs[i].l1);
      end
      check("ar_size_burst", ar_bad, 0);
      check("beats", beat_cnt, vecs[i].beats);
      check("data_order", data_bad, 0);
      check("m_last_pos", last_bad, 0);
      check("error", mri.error, vecs[i].err);
      check("busy_at_done", mri.busy, 0);
      if (vecs[i].imm) begin
        check("done_t1", done_t1, 1);
        check("no_arvalid_t1", arv_t1, 0);
      end else begin
        check("busy_arvalid_t1", {busy_t1, arv_t1}, 2'b11);
        check("done_after_last", done_samp - last_r_samp, 1);
      end
      @(negedge clk);
      #2;
      check("done_pulse", mri.done, 0);
    end
    bp = 0;
    err_beat = -1;
    r_en = 0;
    issue(1, 32'h2000, 32'h800, 128);
    repeat (12) @(negedge clk);
    #2;
    check("stall_ar_count", ar_cnt, 4);
    check("stall_arvalid", arvalid, 0);
    check("stall_busy", mri.busy, 1);
    r_en = 1;
    wait_done();
    check("stall_timeout", to, 0);
    check("stall_total_ars", ar_cnt, 8);
    check("stall_beats", beat_cnt, 128);
    check("stall_data", data_bad, 0);
    check("stall_last", last_bad, 0);
    r_en = 0;
    issue(1, 32'h1000, 32'h100, 16);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    check("midrst_busy", mri.busy, 0);
    check("midrst_arvalid", arvalid, 0);
    check("midrst_araddr", araddr, 0);
    next_addr = 0;
    r_en = 1;
    issue(0, 32'h0, 32'h10, 1);
    wait_done();
    check("midrst_timeout", to, 0);
    check("midrst_cont_addr", ar_a[0], 0);
    check("midrst_cont_len", ar_l[0], 0);
    check("midrst_beats", beat_cnt, 1);
    check("midrst_data", data_bad, 0);
    check("midrst_last", last_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
